pet_update_scheduler: RTL and testbench



---
 rtl/pet_update_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_pet_update_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_update_scheduler.sv
// Single write-path sequencer for the pet stats: merges periodic decay ticks with
// edge-triggered user actions and issues one stat update at a time over valid/ready.
module pet_update_scheduler #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
    parameter logic [3:0]  ACT_AMOUNT = 4'd3,
    parameter logic [7:0]  COOLDOWN   = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    input  logic [3:0] rand_in,
    output logic       upd_valid,
    input  logic       upd_ready,
    output logic [2:0] upd_sel,
    output logic       upd_inc,
    output logic [3:0] upd_amount,
    output logic [5:0] grant,
    output logic       decay_tick,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACT,
        S_DECAY
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] tick_q, tick_d;
    logic [5:0]  req_q, req_prev_q;
    logic [5:0]  act_pend_q, act_pend_d;
    logic        decay_pend_q, decay_pend_d;
    logic [7:0]  cool_q, cool_d;
    logic [2:0]  rr_q, rr_d;
    logic        valid_q, valid_d;
    logic [2:0]  sel_q, sel_d;
    logic        inc_q, inc_d;
    logic [3:0]  amt_q, amt_d;
    logic [5:0]  grant_q, grant_d;
    logic        tick_pulse_q, tick_pulse_d;
    logic        overrun_q, overrun_d;
    logic        busy_q, busy_d;

    logic [5:0]  req_rise;
    logic        tick_wrap;
    logic        ovr_hit;
    logic [5:0]  act_clr;
    logic        cool_load;
    logic        decay_take;
    logic [2:0]  win_idx;
    logic [3:0]  decay_amt;
    logic [2:0]  cand_idx [6];
    logic [5:0]  cand_hit;
    logic        unused_rand;

    function automatic logic [2:0] wrap6(input logic [3:0] v);
        logic [3:0] t;
        t = (v >= 4'd6) ? (v - 4'd6) : v;
        return t[2:0];
    endfunction

    // Only bit 0 of the random source chooses between a decay of 1 or 2.
    assign unused_rand = ^rand_in[3:1];
    assign decay_amt   = 4'd1 + {3'b000, rand_in[0]};

    assign req_rise  = req_q & ~req_prev_q;
    assign tick_wrap = (tick_q == TICK_COUNT - 24'd1);
    assign ovr_hit   = tick_wrap & (decay_pend_q | (state_q == S_DECAY));

    // Candidate gi is the stat gi places above the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_cand
            assign cand_idx[gi] = wrap6({1'b0, rr_q} + 4'(gi));
            assign cand_hit[gi] = act_pend_q[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_idx = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        sel_d      = sel_q;
        inc_d      = inc_q;
        amt_d      = amt_q;
        rr_d       = rr_q;
        grant_d    = 6'd0;
        act_clr    = 6'd0;
        cool_load  = 1'b0;
        decay_take = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (decay_pend_q) begin
                    state_d    = S_DECAY;
                    decay_take = 1'b1;
                    sel_d      = 3'd0;
                    inc_d      = 1'b0;
                end else if ((act_pend_q != 6'd0) && (cool_q == 8'd0)) begin
                    state_d = S_ACT;
                    valid_d = 1'b1;
                    sel_d   = win_idx;
                    inc_d   = 1'b1;
                    amt_d   = ACT_AMOUNT;
                end
            end
            S_ACT: begin
                if (upd_ready) begin
                    grant_d   = 6'd1 << sel_q;
                    act_clr   = 6'd1 << sel_q;
                    rr_d      = wrap6({1'b0, sel_q} + 4'd1);
                    cool_load = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_DECAY: begin
                // First DECAY cycle only samples rand_in; later commands follow back-to-back.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    amt_d   = decay_amt;
                end else if (upd_ready) begin
                    if (sel_q == 3'd5) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        sel_d = sel_q + 3'd1;
                        amt_d = decay_amt;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        tick_d       = tick_wrap ? 24'd0 : (tick_q + 24'd1);
        tick_pulse_d = tick_wrap;
        overrun_d    = overrun_q | ovr_hit;
        decay_pend_d = (decay_pend_q & ~decay_take) | (tick_wrap & ~ovr_hit);
        act_pend_d   = (act_pend_q & ~act_clr) | req_rise;
        busy_d       = (state_d != S_IDLE);
        if (cool_load) begin
            cool_d = COOLDOWN;
        end else if (cool_q != 8'd0) begin
            cool_d = cool_q - 8'd1;
        end else begin
            cool_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_q       <= 24'd0;
            req_q        <= 6'd0;
            req_prev_q   <= 6'd0;
            act_pend_q   <= 6'd0;
            decay_pend_q <= 1'b0;
            cool_q       <= 8'd0;
            rr_q         <= 3'd0;
            valid_q      <= 1'b0;
            sel_q        <= 3'd0;
            inc_q        <= 1'b0;
            amt_q        <= 4'd0;
            grant_q      <= 6'd0;
            tick_pulse_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            req_q        <= req;
            req_prev_q   <= req_q;
            act_pend_q   <= act_pend_d;
            decay_pend_q <= decay_pend_d;
            cool_q       <= cool_d;
            rr_q         <= rr_d;
            valid_q      <= valid_d;
            sel_q        <= sel_d;
            inc_q        <= inc_d;
            amt_q        <= amt_d;
            grant_q      <= grant_d;
            tick_pulse_q <= tick_pulse_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign upd_valid  = valid_q;
    assign upd_sel    = sel_q;
    assign upd_inc    = inc_q;
    assign upd_amount = amt_q;
    assign grant      = grant_q;
    assign decay_tick = tick_pulse_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pet_update_scheduler.sv
// Scoreboarded bench: a job-queue reference model predicts every update transfer,
// and an independent monitor pops and compares whenever the DUT transfers.
module tb_pet_update_scheduler;

    localparam int          TC     = 16;
    localparam logic [3:0]  ACTAMT = 4'd3;
    localparam int          CD     = 8;

    logic       clk;
    logic       rst;
    logic [5:0] req;
    logic [3:0] rand_in;
    logic       upd_valid;
    logic       upd_ready;
    logic [2:0] upd_sel;
    logic       upd_inc;
    logic [3:0] upd_amount;
    logic [5:0] grant;
    logic       decay_tick;
    logic       overrun;
    logic       busy;

    pet_update_scheduler #(
        .TICK_COUNT(24'd16),
        .ACT_AMOUNT(4'd3),
        .COOLDOWN  (8'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rand_in   (rand_in),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_sel   (upd_sel),
        .upd_inc   (upd_inc),
        .upd_amount(upd_amount),
        .grant     (grant),
        .decay_tick(decay_tick),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       inc;
        logic [3:0] amt;
    } cmd_t;

    cmd_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: work queue of stat indices still to be updated in the current job.
    int         m_tick, m_cool, m_rr;
    bit         m_dpend, m_pres, m_decay_job, m_ovr, m_tickp;
    logic [5:0] m_pend, m_h1, m_h2;
    logic [3:0] m_amt;
    int         m_work[$];

    logic       exp_valid, exp_busy, exp_inc, exp_tick, exp_ovr;
    logic [2:0] exp_sel;
    logic [3:0] exp_amt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic publish();
        exp_valid = m_pres;
        exp_busy  = (m_work.size() != 0);
        exp_sel   = (m_work.size() != 0) ? 3'(m_work[0]) : 3'd0;
        exp_inc   = !m_decay_job;
        exp_amt   = m_amt;
        exp_tick  = m_tickp;
        exp_ovr   = m_ovr;
    endtask

    task automatic model_advance(input logic r, input logic [5:0] rq, input logic rdy,
                                 input logic [3:0] rn);
        bit         wrap, cond, take, load;
        logic [5:0] rise, clr;
        int         w, idx;
        if (r) begin
            m_tick = 0; m_cool = 0; m_rr = 0;
            m_dpend = 0; m_pres = 0; m_decay_job = 0; m_ovr = 0; m_tickp = 0;
            m_pend = '0; m_h1 = '0; m_h2 = '0; m_amt = '0;
            m_work.delete();
        end else begin
            wrap = (m_tick == TC - 1);
            cond = m_dpend || ((m_work.size() != 0) && m_decay_job);
            rise = m_h1 & ~m_h2;
            clr  = '0;
            load = 0;
            take = 0;
            if (m_work.size() == 0) begin
                if (m_dpend) begin
                    take = 1;
                    for (int s = 0; s < 6; s++) m_work.push_back(s);
                    m_decay_job = 1;
                    m_pres = 0;
                end else if (m_pend != 0 && m_cool == 0) begin
                    w = -1;
                    for (int k = 0; k < 6; k++) begin
                        idx = (m_rr + k) % 6;
                        if (w < 0 && m_pend[idx]) w = idx;
                    end
                    m_work.push_back(w);
                    m_decay_job = 0;
                    m_pres = 1;
                    m_amt = ACTAMT;
                end
            end else if (!m_pres) begin
                m_pres = 1;
                m_amt = 4'd1 + 4'(rn[0]);
            end else if (rdy) begin
                w = m_work.pop_front();
                if (!m_decay_job) begin
                    clr[w] = 1'b1;
                    m_rr = (w + 1) % 6;
                    load = 1;
                end
                if (m_work.size() == 0) m_pres = 0;
                else m_amt = 4'd1 + 4'(rn[0]);
            end
            m_dpend = (m_dpend && !take) || (wrap && !cond);
            m_ovr   = m_ovr || (wrap && cond);
            m_cool  = load ? CD : ((m_cool > 0) ? m_cool - 1 : 0);
            m_pend  = (m_pend & ~clr) | rise;
            m_tick  = wrap ? 0 : m_tick + 1;
            m_tickp = wrap;
            m_h2 = m_h1;
            m_h1 = rq;
        end
        publish();
    endtask

    // Drives one cycle of inputs, records the transfer the model expects, then advances.
    task automatic step(input logic r, input logic [5:0] rq, input logic rdy);
        logic [3:0] rn;
        cmd_t       c;
        rn = 4'($urandom_range(0, 15));
        rst = r; req = rq; upd_ready = rdy; rand_in = rn;
        if (!r && exp_valid && rdy) begin
            c.sel = exp_sel; c.inc = exp_inc; c.amt = exp_amt;
            sb.push_back(c);
        end
        @(posedge clk); #1;
        model_advance(r, rq, rdy, rn);
    endtask

    // Monitor: per-cycle output checks plus scoreboard pop on every DUT transfer.
    initial begin
        logic [5:0] gexp;
        cmd_t       e;
        gexp = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("grant", 32'(grant), 32'(gexp));
                gexp = '0;
                chk("upd_valid", 32'(upd_valid), 32'(exp_valid));
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("decay_tick", 32'(decay_tick), 32'(exp_tick));
                chk("overrun", 32'(overrun), 32'(exp_ovr));
                if (exp_valid) begin
                    chk("held_sel", 32'(upd_sel), 32'(exp_sel));
                    chk("held_inc", 32'(upd_inc), 32'(exp_inc));
                    chk("held_amount", 32'(upd_amount), 32'(exp_amt));
                end
                if (!rst && upd_valid && upd_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL xfer_unexpected actual sel=%0d required=none", upd_sel);
                    end else begin
                        e = sb.pop_front();
                        chk("xfer_sel", 32'(upd_sel), 32'(e.sel));
                        chk("xfer_inc", 32'(upd_inc), 32'(e.inc));
                        chk("xfer_amount", 32'(upd_amount), 32'(e.amt));
                        if (e.inc) gexp = 6'd1 << e.sel;
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0] rq;
        int         first_tick;
        int         n;
        rst = 1'b1; req = '0; upd_ready = 1'b0; rand_in = '0;
        model_advance(1'b1, '0, 1'b0, '0);

        // Reset, first tick after exactly TC cycles, then decay vs. same-cycle request.
        step(1'b1, '0, 1'b1);
        mon_en = 1'b1;
        step(1'b1, '0, 1'b1);
        step(1'b1, '0, 1'b1);
        chk("rst_valid", 32'(upd_valid), 32'd0);
        chk("rst_sel", 32'(upd_sel), 32'd0);
        chk("rst_inc", 32'(upd_inc), 32'd0);
        chk("rst_amount", 32'(upd_amount), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tick", 32'(decay_tick), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        first_tick = -1;
        for (int i = 1; i <= 45; i++) begin
            step(1'b0, (i >= 15) ? 6'b000100 : 6'b000000, 1'b1);
            if (first_tick < 0 && decay_tick) first_tick = i;
        end
        chk("first_tick_cycle", 32'(first_tick), 32'd16);

        // Round-robin from a fresh pointer.
        step(1'b1, '0, 1'b1);
        step(1'b1, '0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 6'b010001, 1'b1);

        // Back-pressure during an action command.
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        n = 0;
        while (!(exp_valid && exp_inc) && n < 200) begin
            step(1'b0, 6'b001000, 1'b1);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL bp_wait actual=timeout required=action");
        end
        for (int i = 0; i < 5; i++) step(1'b0, 6'b001000, 1'b0);
        step(1'b0, 6'b001000, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 6'b001000, 1'b1);

        // Randomized traffic.
        rq = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 6; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            step(1'b0, rq, ($urandom_range(0, 3) != 0));
        end

        // Reset while the third decay command is presented.
        n = 0;
        while (!(exp_valid && !exp_inc && exp_sel == 3'd2) && n < 200) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL midrst_wait actual=timeout required=decay_cmd2");
        end
        step(1'b1, '0, 1'b0);
        chk("midrst_valid", 32'(upd_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);

        // Overrun: stall across more than a full tick period while decaying.
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0);
        chk("overrun_set", 32'(overrun), 32'd1);
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        step(1'b1, '0, 1'b1);
        step(1'b1, '0, 1'b1);
        chk("overrun_cleared", 32'(overrun), 32'd0);
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
